regfile_wb_arbiter: RTL and testbench

- Writeback stage directly upstream of the 64-bit register file, driving its single write port (we3/wa3/wd3).
- Merges two writeback sources: ALU results, which can be stalled, and data-memory load returns, which cannot be stalled.
- Queues ALU writes in a small FIFO when a load return claims the port.
- Provides a hazard query so the core can detect a pending write to a source register.

---
 rtl/regfile_wb_pkg.sv | 21 ++
 rtl/regfile_wb_arbiter_fifo.sv | 91 +++++++++
 rtl/regfile_wb_arbiter.sv | 120 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared constants and types for the register-file writeback arbiter
// Optional feature macro used by this slice: RFWB_WAW_SQUASH_EN
package regfile_wb_pkg;

    localparam int                DATA_W   = 64;
    localparam int                ADDR_W   = 5;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_LD,
        SRC_FIFO,
        SRC_ALU
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// rtl/regfile_wb_arbiter_fifo.sv - wb_fifo: ALU writeback queue with per-entry address match
// With RFWB_WAW_SQUASH_EN each entry carries a valid bit that a same-address load clears.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  wb_req_t           i_push_req,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_q_addr,
`ifdef RFWB_WAW_SQUASH_EN
    input  logic              i_sq_en,
    input  logic [ADDR_W-1:0] i_sq_addr,
    output logic              o_head_vld,
`endif
    output wb_req_t           o_head,
    output logic [CW-1:0]     o_count,
    output logic [DEPTH-1:0]  o_match
);

    wb_req_t          r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    w_off [DEPTH];
    logic [DEPTH-1:0] w_occ;
`ifdef RFWB_WAW_SQUASH_EN
    logic [DEPTH-1:0] r_vld;
`endif

    // A slot is occupied when its distance from the read pointer is below the count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_off[i] = PW'(i) - r_rptr;
            w_occ[i] = CW'(w_off[i]) < r_count;
`ifdef RFWB_WAW_SQUASH_EN
            o_match[i] = w_occ[i] && r_vld[i] && (r_mem[i].addr == i_q_addr);
`else
            o_match[i] = w_occ[i] && (r_mem[i].addr == i_q_addr);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_push_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
`ifdef RFWB_WAW_SQUASH_EN
            r_vld   <= '0;
`endif
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
`ifdef RFWB_WAW_SQUASH_EN
            for (int i = 0; i < DEPTH; i++) begin
                if (i_sq_en && w_occ[i] && (r_mem[i].addr == i_sq_addr)) begin
                    r_vld[i] <= 1'b0;
                end
            end
            // The load is youngest, so it also kills an ALU entry pushed alongside it.
            if (i_push) begin
                r_vld[r_wptr] <= !(i_sq_en && (i_push_req.addr == i_sq_addr));
            end
`endif
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
`ifdef RFWB_WAW_SQUASH_EN
    assign o_head_vld = r_vld[r_rptr];
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - writeback arbiter driving the register file write port (we3/wa3/wd3)
// Optional macro RFWB_WAW_SQUASH_EN: a selected load invalidates queued same-address ALU writes.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              we3,
    output logic [ADDR_W-1:0] wa3,
    output logic [DATA_W-1:0] wd3,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_hit,
    output logic [CW-1:0]     fifo_count
);

    logic              w_ld_live;
    logic              w_alu_live;
    logic              w_push;
    logic              w_pop;
    logic              w_wr_en;
    logic              w_head_vld;
    wb_src_e           w_sel;
    wb_req_t           w_sel_req;
    wb_req_t           w_head;
    logic [DEPTH-1:0]  w_match;
    logic              r_we3;
    logic [ADDR_W-1:0] r_wa3;
    logic [DATA_W-1:0] r_wd3;

    // Zero-register requests still handshake but never reach the queue or the port.
    assign alu_ready  = reset_n && (fifo_count < CW'(DEPTH));
    assign w_ld_live  = ld_valid && (ld_addr != ZERO_REG);
    assign w_alu_live = alu_valid && alu_ready && (alu_addr != ZERO_REG);

    always_comb begin
        w_sel = SRC_NONE;
        if (w_ld_live) begin
            w_sel = SRC_LD;
        end else if (fifo_count != '0) begin
            w_sel = SRC_FIFO;
        end else if (w_alu_live) begin
            w_sel = SRC_ALU;
        end
    end

    always_comb begin
        w_sel_req = '{addr: alu_addr, data: alu_data};
        w_wr_en   = 1'b0;
        case (w_sel)
            SRC_LD: begin
                w_sel_req = '{addr: ld_addr, data: ld_data};
                w_wr_en   = 1'b1;
            end
            SRC_FIFO: begin
                w_sel_req = w_head;
                w_wr_en   = w_head_vld;
            end
            SRC_ALU: begin
                w_wr_en   = 1'b1;
            end
            default: begin
                w_wr_en   = 1'b0;
            end
        endcase
    end

    assign w_push = w_alu_live && (w_sel != SRC_ALU);
    assign w_pop  = (w_sel == SRC_FIFO);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (reset_n),
        .i_push     (w_push),
        .i_push_req ('{addr: alu_addr, data: alu_data}),
        .i_pop      (w_pop),
        .i_q_addr   (q_addr),
`ifdef RFWB_WAW_SQUASH_EN
        .i_sq_en    (w_ld_live),
        .i_sq_addr  (ld_addr),
        .o_head_vld (w_head_vld),
`endif
        .o_head     (w_head),
        .o_count    (fifo_count),
        .o_match    (w_match)
    );

`ifndef RFWB_WAW_SQUASH_EN
    assign w_head_vld = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we3 <= 1'b0;
            r_wa3 <= '0;
            r_wd3 <= '0;
        end else begin
            r_we3 <= w_wr_en;
            if (w_wr_en) begin
                r_wa3 <= w_sel_req.addr;
                r_wd3 <= w_sel_req.data;
            end
        end
    end

    assign we3   = r_we3;
    assign wa3   = r_wa3;
    assign wd3   = r_wd3;
    assign q_hit = (q_addr != ZERO_REG) && ((|w_match) || (r_we3 && (r_wa3 == q_addr)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized and directed checks of regfile_wb_arbiter against a queue model
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        alu_valid = 1'b0, alu_ready;
    logic [4:0]  alu_addr = '0;
    logic [63:0] alu_data = '0;
    logic        ld_valid = 1'b0;
    logic [4:0]  ld_addr = '0;
    logic [63:0] ld_data = '0;
    logic        we3;
    logic [4:0]  wa3;
    logic [63:0] wd3;
    logic [4:0]  q_addr = '0;
    logic        q_hit;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .q_addr(q_addr), .q_hit(q_hit), .fifo_count(fifo_count)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
        bit          vld;
    } ent_t;

    ent_t        mq[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_wa = '0;
    logic [63:0] m_wd = '0;
    bit          m_acc;
    logic [4:0]  wlog[$];
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_hit(input logic [4:0] a);
        if (a == 5'd31) return 1'b0;
        if (m_we && m_wa == a) return 1'b1;
        foreach (mq[i]) if (mq[i].vld && mq[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    // Called at a falling edge with inputs already applied; advances one clock.
    task automatic step();
        bit   ld_live, alu_live, bypass;
        ent_t e;
        #1;
        chk("alu_ready", alu_ready, mq.size() < DEPTH);
        chk("q_hit", q_hit, model_hit(q_addr));
        m_acc    = alu_valid && (mq.size() < DEPTH);
        ld_live  = ld_valid && ld_addr != 5'd31;
        alu_live = m_acc && alu_addr != 5'd31;
        bypass   = 1'b0;
        if (ld_live) begin
            m_we = 1'b1; m_wa = ld_addr; m_wd = ld_data;
`ifdef RFWB_WAW_SQUASH_EN
            foreach (mq[i]) if (mq[i].addr == ld_addr) mq[i].vld = 1'b0;
`endif
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_we = e.vld;
            if (e.vld) begin m_wa = e.addr; m_wd = e.data; end
        end else if (alu_live) begin
            m_we = 1'b1; m_wa = alu_addr; m_wd = alu_data; bypass = 1'b1;
        end else begin
            m_we = 1'b0;
        end
        if (alu_live && !bypass) begin
            e.addr = alu_addr;
            e.data = alu_data;
`ifdef RFWB_WAW_SQUASH_EN
            e.vld = !(ld_live && alu_addr == ld_addr);
`else
            e.vld = 1'b1;
`endif
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("we3", we3, m_we);
        chk("wa3", wa3, m_wa);
        chk("wd3", wd3, m_wd);
        chk("fifo_count", fifo_count, mq.size());
        if (we3) wlog.push_back(wa3);
        @(negedge clk);
    endtask

    task automatic cyc(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                       input logic lv, input logic [4:0] la, input logic [63:0] ldd,
                       input logic [4:0] qa);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        ld_valid  = lv; ld_addr  = la; ld_data  = ldd;
        q_addr    = qa;
        step();
    endtask

    function automatic logic [4:0] rnd_addr();
        int r;
        r = $urandom_range(0, 8);
        return (r == 8) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        int          acc, k;
        logic [4:0]  exp_full[12];
        logic [4:0]  ra;
        logic [63:0] rd;
        bit          rv;

        #2;
        chk("rst_we3", we3, 0);
        chk("rst_wa3", wa3, 0);
        chk("rst_wd3", wd3, 0);
        chk("rst_count", fifo_count, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Bypass straight to the output register.
        cyc(1, 3, 64'h10, 0, 0, 0, 3);
        chk("byp_we", we3, 1);
        chk("byp_wa", wa3, 3);
        chk("byp_wd", wd3, 64'h10);
        chk("byp_cnt", fifo_count, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Load and ALU collide.
        cyc(1, 6, 64'hBB, 1, 5, 64'hAA, 6);
        chk("cf1_wa", wa3, 5);
        chk("cf1_wd", wd3, 64'hAA);
        chk("cf1_cnt", fifo_count, 1);
        cyc(0, 0, 0, 0, 0, 0, 6);
        chk("cf2_wa", wa3, 6);
        chk("cf2_wd", wd3, 64'hBB);
        chk("cf2_cnt", fifo_count, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Fill the FIFO behind six back-to-back loads.
        wlog.delete();
        acc = 0;
        k = 1;
        for (int c = 0; c < 6; c++) begin
            cyc(1, 5'(k), 64'(100 + k), 1, 5'(20 + c), 64'(c), 5'(k));
            if (m_acc) begin acc++; k++; end
        end
        chk("full_accepts", acc, 4);
        for (int n = 0; n < 20 && k <= 6; n++) begin
            cyc(1, 5'(k), 64'(100 + k), 0, 0, 0, 1);
            if (m_acc) k++;
        end
        repeat (6) cyc(0, 0, 0, 0, 0, 0, 0);
        exp_full = '{20, 21, 22, 23, 24, 25, 1, 2, 3, 4, 5, 6};
        chk("full_nwrites", wlog.size(), 12);
        for (int i = 0; i < 12 && i < wlog.size(); i++) chk("full_order", wlog[i], exp_full[i]);

        // Zero-register requests vanish.
        wlog.delete();
        cyc(1, 31, 64'h5, 1, 31, 64'h6, 31);
        chk("zr_qhit", q_hit, 0);
        chk("zr_cnt", fifo_count, 0);
        cyc(0, 0, 0, 0, 0, 0, 31);
        chk("zr_nwrites", wlog.size(), 0);

        // Write-after-write to r7: ALU entry queued, then a load to the same register.
        cyc(1, 7, 64'h1, 1, 8, 64'h5, 7);
        chk("waw_cnt", fifo_count, 1);
        cyc(0, 0, 0, 1, 7, 64'h2, 7);
        chk("waw_ld_wa", wa3, 7);
        chk("waw_ld_wd", wd3, 64'h2);
        chk("waw_qhit", q_hit, 1);
        cyc(0, 0, 0, 0, 0, 0, 7);
`ifdef RFWB_WAW_SQUASH_EN
        chk("waw_pop_we", we3, 0);
        chk("waw_pop_wd", wd3, 64'h2);
`else
        chk("waw_pop_we", we3, 1);
        chk("waw_pop_wd", wd3, 64'h1);
`endif
        chk("waw_pop_cnt", fifo_count, 0);

        // Asynchronous reset with two queued entries.
        cyc(1, 1, 64'h11, 1, 20, 64'h20, 0);
        cyc(1, 2, 64'h12, 1, 21, 64'h21, 0);
        chk("pre_rst_cnt", fifo_count, 2);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_we3", we3, 0);
        chk("arst_cnt", fifo_count, 0);
        mq.delete();
        m_we = 1'b0; m_wa = '0; m_wd = '0;
        alu_valid = 1'b0; ld_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_rst_ready", alu_ready, 1);
        wlog.delete();
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 1);
        chk("post_rst_nwrites", wlog.size(), 0);

        // Randomized traffic; the ALU holds its request until accepted.
        rv = 1'b0;
        ra = '0;
        rd = '0;
        repeat (400) begin
            if (!rv && $urandom_range(0, 9) < 7) begin
                rv = 1'b1;
                ra = rnd_addr();
                rd = {$urandom, $urandom};
            end
            cyc(rv, ra, rd, $urandom_range(0, 9) < 4, rnd_addr(), {$urandom, $urandom}, rnd_addr());
            if (m_acc) rv = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
